// File: rtl/pcie_cfg_mgmt_responder_if.sv
// ----------------------------------------------------------------------------
// pcie_cfg_mgmt_responder_if
//   Bundle of the PCIe hard-IP configuration management port.
//
//   master : initiator side (fpga_core) - drives the request, samples results
//   slave  : responder side (hard IP or its stand-in) - the mirror image
//
//   cfg_mgmt_addr             DWORD address
//   cfg_mgmt_function_number  target function
//   cfg_mgmt_write            write request, held until done
//   cfg_mgmt_write_data       write data
//   cfg_mgmt_byte_enable      per-byte write enable
//   cfg_mgmt_read             read request, held until done
//   cfg_mgmt_read_data        read data, valid with done
//   cfg_mgmt_read_write_done  one-cycle completion pulse
//   protocol_error            one-cycle pulse on an illegal request
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface pcie_cfg_mgmt_responder_if;
  logic [9:0]  cfg_mgmt_addr;
  logic [7:0]  cfg_mgmt_function_number;
  logic        cfg_mgmt_write;
  logic [31:0] cfg_mgmt_write_data;
  logic [3:0]  cfg_mgmt_byte_enable;
  logic        cfg_mgmt_read;
  logic [31:0] cfg_mgmt_read_data;
  logic        cfg_mgmt_read_write_done;
  logic        protocol_error;

  modport master (
    output cfg_mgmt_addr,
    output cfg_mgmt_function_number,
    output cfg_mgmt_write,
    output cfg_mgmt_write_data,
    output cfg_mgmt_byte_enable,
    output cfg_mgmt_read,
    input  cfg_mgmt_read_data,
    input  cfg_mgmt_read_write_done,
    input  protocol_error
  );

  modport slave (
    input  cfg_mgmt_addr,
    input  cfg_mgmt_function_number,
    input  cfg_mgmt_write,
    input  cfg_mgmt_write_data,
    input  cfg_mgmt_byte_enable,
    input  cfg_mgmt_read,
    output cfg_mgmt_read_data,
    output cfg_mgmt_read_write_done,
    output protocol_error
  );
endinterface

// File: rtl/pcie_cfg_mgmt_responder.sv
// ----------------------------------------------------------------------------
// pcie_cfg_mgmt_responder
//   Completer end of the PCIe configuration management port. Answers
//   cfg_mgmt read/write requests from a small per-function register file
//   after a fixed response latency, so the core's initiator logic can be
//   exercised without the hard IP.
//
//   Ports
//     clk       PCIe user clock
//     rst       synchronous, active-high reset
//     cfg_mgmt  slave modport of pcie_cfg_mgmt_responder_if
//
//   Optional build macro
//     CFG_MGMT_RESP_JITTER_EN  adds 0..7 pseudo-random cycles (16-bit LFSR)
//                              to every response latency.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module pcie_cfg_mgmt_responder #(
  parameter int unsigned NUM_FUNCS    = 4,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned RESP_LATENCY = 3,
  parameter logic [31:0] ID_VALUE     = 32'h903F10EE
) (
  input logic                    clk,
  input logic                    rst,
  pcie_cfg_mgmt_responder_if.slave cfg_mgmt
);

  localparam int unsigned AW    = (DEPTH > 1)     ? $clog2(DEPTH)     : 1;
  localparam int unsigned FW    = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1;
  localparam int unsigned WORDS = NUM_FUNCS * DEPTH;
  localparam int unsigned CW    = 5;  // holds RESP_LATENCY + 7 - 1 at most

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    addr_q, addr_d;
  logic [7:0]    func_q, func_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          perr_q, perr_d;

  logic [31:0]   mem_q [0:WORDS-1];

  logic          in_range;
  logic [FW+AW-1:0] idx;
  logic          mem_we;
  logic [CW-1:0] eff_lat;

  // --------------------------------------------------------------------------
  // Response latency, optionally stretched by a free-running LFSR.
  // --------------------------------------------------------------------------
`ifdef CFG_MGMT_RESP_JITTER_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  assign eff_lat = CW'(RESP_LATENCY) + CW'(lfsr_q[2:0]);
`else
  assign eff_lat = CW'(RESP_LATENCY);
`endif

  // The range check uses the full address and function number, so the
  // truncated index below can never alias onto another word.
  assign in_range = ({1'b0, addr_q} < 11'(DEPTH)) && ({1'b0, func_q} < 9'(NUM_FUNCS));
  assign idx      = {func_q[FW-1:0], addr_q[AW-1:0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      func_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      func_q  <= func_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    func_d  = func_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_mgmt.cfg_mgmt_read || cfg_mgmt.cfg_mgmt_write) begin
          addr_d  = cfg_mgmt.cfg_mgmt_addr;
          func_d  = cfg_mgmt.cfg_mgmt_function_number;
          wdata_d = cfg_mgmt.cfg_mgmt_write_data;
          be_d    = cfg_mgmt.cfg_mgmt_byte_enable;
          // Simultaneous read and write resolves to a write, flagged.
          is_wr_d = cfg_mgmt.cfg_mgmt_write;
          perr_d  = cfg_mgmt.cfg_mgmt_write && cfg_mgmt.cfg_mgmt_read;
          cnt_d   = eff_lat - CW'(1);
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
          if (is_wr_q) begin
            mem_we = in_range && (addr_q != 10'd0);
          end else if (!in_range) begin
            rdata_d = 32'h0;
          end else if (addr_q == 10'd0) begin
            rdata_d = ID_VALUE;
          end else begin
            rdata_d = mem_q[idx];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // One dead cycle so a request still held from the last done is not
      // taken as a new one.
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  // NOTE: the storage array is reset on purpose: a reset must wipe every
  // function's registers, so this stays flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign cfg_mgmt.cfg_mgmt_read_data       = rdata_q;
  assign cfg_mgmt.cfg_mgmt_read_write_done = done_q;
  assign cfg_mgmt.protocol_error           = perr_q;

endmodule

// File: tb/tb_pcie_cfg_mgmt_responder.sv
// ----------------------------------------------------------------------------
// tb_pcie_cfg_mgmt_responder
//   Self-checking bench: directed scenarios plus randomized traffic, checked
//   against a behavioural register-file model held in plain arrays.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pcie_cfg_mgmt_responder;

  localparam int unsigned NF       = 4;
  localparam int unsigned DP       = 16;
  localparam int unsigned RESP_LAT = 3;
  localparam logic [31:0] ID       = 32'h903F10EE;

  logic clk = 1'b0;
  logic rst;

  pcie_cfg_mgmt_responder_if cfg_if ();

  pcie_cfg_mgmt_responder dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_mgmt (cfg_if)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] model_mem [0:NF-1][0:DP-1];
  logic [31:0] exp_rdata;
  int unsigned exp_dones  = 0;
  int unsigned done_total = 0;

  always @(negedge clk) if (!rst && cfg_if.cfg_mgmt_read_write_done) done_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_in_range(logic [7:0] fn, logic [9:0] ad);
    return (fn < NF) && (ad < DP);
  endfunction

  function automatic logic [31:0] model_read(logic [7:0] fn, logic [9:0] ad);
    if (!model_in_range(fn, ad)) return 32'h0;
    if (ad == 10'd0) return ID;
    return model_mem[fn][ad];
  endfunction

  task automatic model_write(input logic [7:0] fn, input logic [9:0] ad,
                             input logic [31:0] wd, input logic [3:0] be);
    if (model_in_range(fn, ad) && ad != 10'd0) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[fn][ad][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic model_clear();
    for (int f = 0; f < NF; f++)
      for (int a = 0; a < DP; a++) model_mem[f][a] = 32'h0;
    exp_rdata = 32'h0;
  endtask

  // Issues one request with the DUT idle; returns #1 after the edge that
  // ends the post-done dead cycle. hold keeps the lines asserted on return;
  // drop_early releases them right after the acceptance edge.
  task automatic do_txn(input bit wr, input bit rd, input logic [7:0] fn,
                        input logic [9:0] ad, input logic [31:0] wd,
                        input logic [3:0] be, input bit hold, input bit drop_early);
    int unsigned cycles;
    int unsigned perr_seen;
    cfg_if.cfg_mgmt_write           = wr;
    cfg_if.cfg_mgmt_read            = rd;
    cfg_if.cfg_mgmt_function_number = fn;
    cfg_if.cfg_mgmt_addr            = ad;
    cfg_if.cfg_mgmt_write_data      = wd;
    cfg_if.cfg_mgmt_byte_enable     = be;
    @(posedge clk); #1;
    perr_seen = cfg_if.protocol_error ? 1 : 0;
    if (drop_early) begin
      cfg_if.cfg_mgmt_write = 1'b0;
      cfg_if.cfg_mgmt_read  = 1'b0;
    end
    cycles = 0;
    while (!cfg_if.cfg_mgmt_read_write_done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (cfg_if.protocol_error) perr_seen++;
    end
    if (!cfg_if.cfg_mgmt_read_write_done) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      exp_dones++;
`ifdef CFG_MGMT_RESP_JITTER_EN
      check("latency_in_3_to_10", 32'(cycles >= 3 && cycles <= 10), 32'd1);
`else
      check("latency", cycles, RESP_LAT);
`endif
      if (wr) model_write(fn, ad, wd, be);
      else    exp_rdata = model_read(fn, ad);
      check($sformatf("read_data f%0d a%0h %s", fn, ad, wr ? "wr" : "rd"),
            cfg_if.cfg_mgmt_read_data, exp_rdata);
      check("protocol_error_cycles", perr_seen, 32'(wr && rd));
    end
    if (!hold) begin
      cfg_if.cfg_mgmt_write = 1'b0;
      cfg_if.cfg_mgmt_read  = 1'b0;
    end
    @(posedge clk); #1;
    check("done_single_cycle", 32'(cfg_if.cfg_mgmt_read_write_done), 32'd0);
  endtask

  task automatic rd_txn(input logic [7:0] fn, input logic [9:0] ad);
    do_txn(1'b0, 1'b1, fn, ad, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic wr_txn(input logic [7:0] fn, input logic [9:0] ad,
                        input logic [31:0] wd, input logic [3:0] be);
    do_txn(1'b1, 1'b0, fn, ad, wd, be, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cfg_if.cfg_mgmt_write           = 1'b0;
    cfg_if.cfg_mgmt_read            = 1'b0;
    cfg_if.cfg_mgmt_addr            = '0;
    cfg_if.cfg_mgmt_function_number = '0;
    cfg_if.cfg_mgmt_write_data      = '0;
    cfg_if.cfg_mgmt_byte_enable     = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_done",      32'(cfg_if.cfg_mgmt_read_write_done), 32'd0);
    check("reset_read_data", cfg_if.cfg_mgmt_read_data, 32'h0);
    check("reset_perr",      32'(cfg_if.protocol_error), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ID word, byte-enabled write, isolation between functions.
    rd_txn(8'd0, 10'd0);
    wr_txn(8'd1, 10'd5, 32'hDEADBEEF, 4'b0101);
    rd_txn(8'd1, 10'd5);
    check("be_merge_value", cfg_if.cfg_mgmt_read_data, 32'h00AD00EF);
    rd_txn(8'd2, 10'd5);

    // DWORD 0 is read-only; a write completion keeps the last read data.
    wr_txn(8'd0, 10'd0, 32'h12345678, 4'hF);
    rd_txn(8'd0, 10'd0);

    // Out-of-range reads and writes, including would-be aliases.
    rd_txn(8'd0, 10'h3FF);
    rd_txn(8'd7, 10'd1);
    wr_txn(8'd3, 10'd16, 32'hA5A5A5A5, 4'hF);
    wr_txn(8'd2, 10'd17, 32'h11223344, 4'hF);
    wr_txn(8'd4, 10'd1,  32'h55667788, 4'hF);
    rd_txn(8'd3, 10'd0);
    rd_txn(8'd2, 10'd1);
    rd_txn(8'd0, 10'd1);
    rd_txn(8'd1, 10'd5);

    // Read and write together: treated as a write, protocol_error pulses.
    do_txn(1'b1, 1'b1, 8'd2, 10'd7, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
    rd_txn(8'd2, 10'd7);

    // Four back-to-back requests with the lines held through each done.
    do_txn(1'b1, 1'b0, 8'd3, 10'd9, 32'h01020304, 4'hF, 1'b1, 1'b0);
    do_txn(1'b0, 1'b1, 8'd3, 10'd9, 32'h0,        4'h0, 1'b1, 1'b0);
    do_txn(1'b1, 1'b0, 8'd3, 10'd9, 32'hFFFFFFFF, 4'b1000, 1'b1, 1'b0);
    do_txn(1'b0, 1'b1, 8'd3, 10'd9, 32'h0,        4'h0, 1'b0, 1'b0);

    // Request dropped right after acceptance still completes.
    do_txn(1'b1, 1'b0, 8'd1, 10'd2, 32'h0BADF00D, 4'hF, 1'b0, 1'b1);
    do_txn(1'b0, 1'b1, 8'd1, 10'd2, 32'h0,        4'h0, 1'b0, 1'b1);

    // Reset while a write is in BUSY: no done, storage cleared.
    cfg_if.cfg_mgmt_write           = 1'b1;
    cfg_if.cfg_mgmt_read            = 1'b0;
    cfg_if.cfg_mgmt_function_number = 8'd1;
    cfg_if.cfg_mgmt_addr            = 10'd3;
    cfg_if.cfg_mgmt_write_data      = 32'h77777777;
    cfg_if.cfg_mgmt_byte_enable     = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_done",  32'(cfg_if.cfg_mgmt_read_write_done), 32'd0);
    check("reset_mid_rdata", cfg_if.cfg_mgmt_read_data, 32'h0);
    rst = 1'b0;
    cfg_if.cfg_mgmt_write = 1'b0;
    model_clear();
    repeat (6) begin
      @(posedge clk); #1;
      check("no_done_after_abort", 32'(cfg_if.cfg_mgmt_read_write_done), 32'd0);
    end
    rd_txn(8'd1, 10'd3);
    rd_txn(8'd1, 10'd5);
    rd_txn(8'd2, 10'd7);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      int unsigned r;
      logic [7:0]  fn;
      logic [9:0]  ad;
      r  = $urandom_range(0, 9);
      fn = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) ad = 10'($urandom);
      else                           ad = 10'($urandom_range(0, 17));
      do_txn(r <= 3, r >= 3, fn, ad, $urandom, 4'($urandom_range(0, 15)),
             1'b0, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Latency sweep over 64 reads.
    for (int n = 0; n < 64; n++) rd_txn(8'($urandom_range(0, 3)), 10'($urandom_range(0, 15)));

    repeat (5) @(posedge clk);
    #1;
    check("done_pulse_count", done_total, exp_dones);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
